// File: rtl/dequant_if.sv
// Valid/ready bundle between the level decoder, the dequantizer and the
// reconstruction output. The dequantizer takes the slave view; the upstream
// and downstream agents together take the master view.
interface dequant_if #(
    parameter int LEVEL_WIDTH = 6,
    parameter int STEP_WIDTH  = 9,
    parameter int RECON_WIDTH = LEVEL_WIDTH + STEP_WIDTH
);
    logic                   in_valid;
    logic                   in_ready;
    logic [LEVEL_WIDTH-1:0] level;
    logic [STEP_WIDTH-1:0]  step;
    logic                   out_valid;
    logic                   out_ready;
    logic [RECON_WIDTH-1:0] recon;

    modport master (
        output in_valid,
        output level,
        output step,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  recon
    );

    modport slave (
        input  in_valid,
        input  level,
        input  step,
        input  out_ready,
        output in_ready,
        output out_valid,
        output recon
    );
endinterface

// File: rtl/dequant_multiplier.sv
// Dequantizer: rebuilds a sample at the middle of its quantization bin,
//   recon = level*step + (level != 0 ? step>>1 : 0)
// using a shift-add multiplier that retires one level bit per clock. The
// midpoint offset is preloaded into the accumulator at accept time, so the
// multiply loop itself is a plain shift-add and latency never depends on data.
module dequant_multiplier #(
    parameter int LEVEL_WIDTH = 6,
    parameter int STEP_WIDTH  = 9,
    parameter int RECON_WIDTH = LEVEL_WIDTH + STEP_WIDTH
) (
    input  logic     clk,
    input  logic     rst,
    dequant_if.slave bus
);

    // Wide enough to hold LEVEL_WIDTH-1 even when LEVEL_WIDTH is a power of two.
    localparam int CNT_W = $clog2(LEVEL_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(LEVEL_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_r;
    logic                   in_ready_r;
    logic                   out_valid_r;
    logic [RECON_WIDTH-1:0] recon_r;
    logic [RECON_WIDTH-1:0] acc_r;
    logic [RECON_WIDTH-1:0] mcand_r;
    logic [LEVEL_WIDTH-1:0] mult_sh_r;
    logic [CNT_W-1:0]       bitcnt_r;
    logic [RECON_WIDTH-1:0] acc_next_s;

    // Bin-midpoint offset; a zero level reconstructs to exactly zero.
    function automatic logic [RECON_WIDTH-1:0] mid_offset(
        input logic [LEVEL_WIDTH-1:0] lvl,
        input logic [STEP_WIDTH-1:0]  stp
    );
        logic [STEP_WIDTH-1:0] half;
        half = stp >> 1'b1;
        if (lvl != {LEVEL_WIDTH{1'b0}}) begin
            return {{(RECON_WIDTH-STEP_WIDTH){1'b0}}, half};
        end else begin
            return {RECON_WIDTH{1'b0}};
        end
    endfunction

    // Partial-product add for the level bit currently at the bottom of the shifter.
    always_comb begin
        acc_next_s = acc_r;
        if (mult_sh_r[0]) begin
            acc_next_s = acc_r + mcand_r;
        end else begin
            acc_next_s = acc_r;
        end
    end

    // Control FSM and datapath registers; all handshake outputs are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            recon_r     <= {RECON_WIDTH{1'b0}};
            acc_r       <= {RECON_WIDTH{1'b0}};
            mcand_r     <= {RECON_WIDTH{1'b0}};
            mult_sh_r   <= {LEVEL_WIDTH{1'b0}};
            bitcnt_r    <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        mult_sh_r  <= bus.level;
                        mcand_r    <= {{(RECON_WIDTH-STEP_WIDTH){1'b0}}, bus.step};
                        acc_r      <= mid_offset(bus.level, bus.step);
                        bitcnt_r   <= {CNT_W{1'b0}};
                        in_ready_r <= 1'b0;
                        state_r    <= MUL;
                    end
                end
                MUL: begin
                    acc_r     <= acc_next_s;
                    mcand_r   <= mcand_r << 1'b1;
                    mult_sh_r <= mult_sh_r >> 1'b1;
                    bitcnt_r  <= bitcnt_r + CNT_W'(1);
                    if (bitcnt_r == LAST_BIT) begin
                        // Last bit: publish the result straight from the adder.
                        recon_r     <= acc_next_s;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end
                end
                DONE: begin
                    // recon_r is untouched here, so it is stable while stalled.
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.recon     = recon_r;

endmodule
